// File: rtl/bt_cmd_decoder_if.sv
// Decoder-side bundle: held receiver fields and game state in, step pulses and
// command strobes out. master = bt_cmd_decoder, slave = game controller side.
interface bt_cmd_decoder_if;
    logic [1:0] dir;
    logic [2:0] choice;
    logic [2:0] state;
    logic       step_l;
    logic       step_r;
    logic       cmd_valid;
    logic [2:0] cmd_code;

    modport master (
        input  dir, choice, state,
        output step_l, step_r, cmd_valid, cmd_code
    );

    modport slave (
        output dir, choice, state,
        input  step_l, step_r, cmd_valid, cmd_code
    );
endinterface

// File: rtl/bt_cmd_decoder.sv
// Deglitches Bluetooth dir/choice levels into step pulses and command strobes.
// Define BT_AUTOREPEAT_EN to enable auto-repeat of held directions.
module bt_cmd_decoder #(
    parameter int STABLE_CYC    = 100000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int CW            = 26
) (
    input  logic                clk,
    input  logic                rst,
    bt_cmd_decoder_if.master    bus
);
    localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC - 1);

    if ((CW < $clog2(REPEAT_DELAY + 1)) || (CW < $clog2(REPEAT_PERIOD + 1))) begin : g_cw_check
        $error("CW too narrow for repeat counters");
    end

`ifdef BT_AUTOREPEAT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FIRST = 2'd1, ST_REPEAT = 2'd2} dir_fsm_t;
    localparam logic [CW-1:0] DELAY_MAX  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_MAX = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] rcnt_r;
    logic          rep_s;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FIRST = 2'd1} dir_fsm_t;
`endif

    dir_fsm_t      fsm_r;
    logic [1:0]    dir_dec_s;
    logic [1:0]    dir_q_r;
    logic [1:0]    dir_f_r;
    logic [1:0]    dir_cur_r;
    logic [SW-1:0] dir_cnt_r;
    logic [2:0]    choice_q_r;
    logic [2:0]    choice_f_r;
    logic [SW-1:0] choice_cnt_r;
    logic          choice_load_r;
    logic          playing_s;
    logic          dir_live_s;
    logic          fresh_s;
    logic          step_l_r;
    logic          step_r_r;
    logic          cmd_valid_r;
    logic [2:0]    cmd_code_r;

    // 11 carries no direction, so fold it into "none" before filtering.
    assign dir_dec_s  = (bus.dir == 2'b11) ? 2'b00 : bus.dir;
    assign playing_s  = (bus.state == 3'b010);
    assign dir_live_s = (dir_f_r != 2'b00);
    assign fresh_s    = dir_live_s && ((fsm_r == ST_IDLE) || (dir_f_r != dir_cur_r));

    // Direction input register and stability filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q_r   <= 2'b00;
            dir_cnt_r <= {SW{1'b0}};
            dir_f_r   <= 2'b00;
        end else begin
            dir_q_r <= dir_dec_s;
            if (dir_dec_s != dir_q_r) begin
                dir_cnt_r <= {SW{1'b0}};
            end else if (dir_cnt_r != STAB_MAX) begin
                dir_cnt_r <= dir_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                dir_cnt_r <= dir_cnt_r;
            end
            if ((dir_cnt_r == STAB_MAX) && (dir_q_r != dir_f_r)) begin
                dir_f_r <= dir_q_r;
            end else begin
                dir_f_r <= dir_f_r;
            end
        end
    end

    // Choice input register and stability filter; flags each accepted change.
    always_ff @(posedge clk) begin
        if (rst) begin
            choice_q_r    <= 3'b000;
            choice_cnt_r  <= {SW{1'b0}};
            choice_f_r    <= 3'b000;
            choice_load_r <= 1'b0;
        end else begin
            choice_q_r <= bus.choice;
            if (bus.choice != choice_q_r) begin
                choice_cnt_r <= {SW{1'b0}};
            end else if (choice_cnt_r != STAB_MAX) begin
                choice_cnt_r <= choice_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                choice_cnt_r <= choice_cnt_r;
            end
            if ((choice_cnt_r == STAB_MAX) && (choice_q_r != choice_f_r)) begin
                choice_f_r    <= choice_q_r;
                choice_load_r <= 1'b1;
            end else begin
                choice_f_r    <= choice_f_r;
                choice_load_r <= 1'b0;
            end
        end
    end

`ifdef BT_AUTOREPEAT_EN
    // Repeat deadline for the current hold phase.
    always_comb begin
        rep_s = 1'b0;
        case (fsm_r)
            ST_FIRST:  rep_s = (rcnt_r == DELAY_MAX);
            ST_REPEAT: rep_s = (rcnt_r == PERIOD_MAX);
            default:   rep_s = 1'b0;
        endcase
    end
`endif

    // Direction FSM: fresh presses pulse immediately, held presses optionally repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r     <= ST_IDLE;
            dir_cur_r <= 2'b00;
            step_l_r  <= 1'b0;
            step_r_r  <= 1'b0;
`ifdef BT_AUTOREPEAT_EN
            rcnt_r    <= {CW{1'b0}};
`endif
        end else if (!playing_s || !dir_live_s) begin
            fsm_r     <= ST_IDLE;
            dir_cur_r <= 2'b00;
            step_l_r  <= 1'b0;
            step_r_r  <= 1'b0;
`ifdef BT_AUTOREPEAT_EN
            rcnt_r    <= {CW{1'b0}};
`endif
        end else if (fresh_s) begin
            fsm_r     <= ST_FIRST;
            dir_cur_r <= dir_f_r;
            step_l_r  <= (dir_f_r == 2'b01);
            step_r_r  <= (dir_f_r == 2'b10);
`ifdef BT_AUTOREPEAT_EN
            rcnt_r    <= {CW{1'b0}};
        end else if (rep_s) begin
            fsm_r     <= ST_REPEAT;
            dir_cur_r <= dir_cur_r;
            step_l_r  <= (dir_cur_r == 2'b01);
            step_r_r  <= (dir_cur_r == 2'b10);
            rcnt_r    <= {CW{1'b0}};
        end else begin
            fsm_r     <= fsm_r;
            dir_cur_r <= dir_cur_r;
            step_l_r  <= 1'b0;
            step_r_r  <= 1'b0;
            rcnt_r    <= rcnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
`else
        end else begin
            fsm_r     <= fsm_r;
            dir_cur_r <= dir_cur_r;
            step_l_r  <= 1'b0;
            step_r_r  <= 1'b0;
        end
`endif
    end

    // Command strobe: 000 and 011 (move mode) update the filter silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= 3'b000;
        end else if (choice_load_r && (choice_f_r != 3'b000) && (choice_f_r != 3'b011)) begin
            cmd_valid_r <= 1'b1;
            cmd_code_r  <= choice_f_r;
        end else begin
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= cmd_code_r;
        end
    end

    assign bus.step_l    = step_l_r;
    assign bus.step_r    = step_r_r;
    assign bus.cmd_valid = cmd_valid_r;
    assign bus.cmd_code  = cmd_code_r;

endmodule
